// File: rtl/riscuva_irq_pkg.sv
// rtl/riscuva_irq_pkg.sv - shared types and constants for the RISCuva interrupt controller
package riscuva_irq_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } irqState_t;

   localparam logic [1:0] REG_PEND = 2'd0;
   localparam logic [1:0] REG_MASK = 2'd1;
   localparam logic [1:0] REG_EDGE = 2'd2;
   localparam logic [1:0] REG_VECT = 2'd3;

   localparam logic [3:0] SPURIOUS_CODE = 4'h8;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - find-first-set priority encoder, lowest index wins
module irq_prio_enc #(
   parameter int N_SRC = 8
) (
   input  logic [N_SRC-1:0] req_i,
   output logic             valid_o,
   output logic [3:0]       index_o
);

   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      valid_o = 1'b0;
      index_o = 4'h0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            valid_o = 1'b1;
            index_o = 4'(i);
         end
      end
   end

endmodule

// File: rtl/riscuva_irq_ctrl.sv
// rtl/riscuva_irq_ctrl.sv - prioritised 8-source interrupt controller on the RISCuva port bus
module riscuva_irq_ctrl
   import riscuva_irq_pkg::*;
#(
   parameter int         N_SRC = 8,
   parameter logic [7:0] BASE  = 8'hF0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N_SRC-1:0] irqSrc,
   output logic             intReq,
   input  logic             intAck,
   input  logic [7:0]       portAddress,
   input  logic             portRead,
   input  logic             portWrite,
   input  logic [7:0]       portWrData,
   output logic [7:0]       portRdData,
   output logic             portSel
);

   logic [N_SRC-1:0] sync1_q, sync2_q, sync3_q;
   logic [N_SRC-1:0] pend_q, pend_d;
   logic [N_SRC-1:0] mask_q, edge_q;
   logic [N_SRC-1:0] rise, w1c, claim_clr;
   logic [3:0]       code_q, code_d;
   logic             in_service_q, in_service_d;
   logic             ack_q, ack_rise;
   logic             int_req_q;
   logic             claim_hit, claim_spur;
   logic             blk_hit, wr_pend, wr_mask, wr_edge;
   logic             cand_valid;
   logic [3:0]       cand_idx;
   logic [7:0]       rd_data;
   irqState_t        state_q, state_d;

   assign blk_hit = (portAddress[7:2] == BASE[7:2]);
   assign portSel = blk_hit & portRead;
   assign wr_pend = blk_hit & portWrite & (portAddress[1:0] == REG_PEND);
   assign wr_mask = blk_hit & portWrite & (portAddress[1:0] == REG_MASK);
   assign wr_edge = blk_hit & portWrite & (portAddress[1:0] == REG_EDGE);

   assign rise     = sync2_q & ~sync3_q;
   assign w1c      = wr_pend ? portWrData[N_SRC-1:0] : '0;
   assign ack_rise = intAck & ~ack_q;
   assign intReq   = int_req_q;

   irq_prio_enc #(.N_SRC(N_SRC)) u_prio (
      .req_i   (pend_q & mask_q),
      .valid_o (cand_valid),
      .index_o (cand_idx)
   );

   // Two-stage synchronizer plus a third stage for rising-edge detection.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         sync3_q <= '0;
      end else begin
         sync1_q <= irqSrc;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   // Edge bits latch rises and clear on W1C or claim (set wins); level bits track sync2.
   always_comb begin
      pend_d    = '0;
      claim_clr = '0;
      for (int i = 0; i < N_SRC; i++) begin
         claim_clr[i] = claim_hit && (cand_idx == 4'(i)) && edge_q[i];
         if (edge_q[i]) begin
            pend_d[i] = rise[i] | (pend_q[i] & ~(w1c[i] | claim_clr[i]));
         end else begin
            pend_d[i] = sync2_q[i];
         end
      end
   end

   // Configuration and pending registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pend_q <= '0;
         mask_q <= '0;
         edge_q <= '0;
      end else begin
         pend_q <= pend_d;
         if (wr_mask) mask_q <= portWrData[N_SRC-1:0];
         if (wr_edge) edge_q <= portWrData[N_SRC-1:0];
      end
   end

   // Request/service sequencing; an ack seen from IDLE is a raced withdrawal.
   always_comb begin
      state_d      = state_q;
      code_d       = code_q;
      in_service_d = in_service_q;
      claim_hit    = 1'b0;
      claim_spur   = 1'b0;
      case (state_q)
         IDLE: begin
            if (ack_rise) begin
               state_d    = SERVICE;
               claim_spur = 1'b1;
            end else if (cand_valid && !intAck) begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (ack_rise) begin
               state_d    = SERVICE;
               claim_hit  = cand_valid;
               claim_spur = !cand_valid;
            end else if (!cand_valid) begin
               state_d = IDLE;
            end
         end
         SERVICE: begin
            if (!intAck) begin
               state_d      = IDLE;
               in_service_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      if (claim_hit) begin
         code_d       = cand_idx;
         in_service_d = 1'b1;
      end else if (claim_spur) begin
         code_d       = SPURIOUS_CODE;
         in_service_d = 1'b1;
      end
   end

   // FSM state, vector register and registered request output.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         code_q       <= 4'h0;
         in_service_q <= 1'b0;
         ack_q        <= 1'b0;
         int_req_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         code_q       <= code_d;
         in_service_q <= in_service_d;
         ack_q        <= intAck;
         int_req_q    <= (state_d == REQ);
      end
   end

   // Combinational read mux, forced to zero when the block is not selected.
   always_comb begin
      rd_data = 8'h00;
      case (portAddress[1:0])
         REG_PEND: rd_data = 8'(pend_q);
         REG_MASK: rd_data = 8'(mask_q);
         REG_EDGE: rd_data = 8'(edge_q);
         REG_VECT: rd_data = {in_service_q, 3'b000, code_q};
         default:  rd_data = 8'h00;
      endcase
      portRdData = portSel ? rd_data : 8'h00;
   end

endmodule

// File: tb/tb_riscuva_irq_ctrl.sv
// tb/tb_riscuva_irq_ctrl.sv - self-checking bench for riscuva_irq_ctrl
module tb_riscuva_irq_ctrl;

   localparam logic [7:0] A_PEND = 8'hF0;
   localparam logic [7:0] A_MASK = 8'hF1;
   localparam logic [7:0] A_EDGE = 8'hF2;
   localparam logic [7:0] A_VECT = 8'hF3;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] irqSrc;
   logic       intReq;
   logic       intAck;
   logic [7:0] portAddress;
   logic       portRead;
   logic       portWrite;
   logic [7:0] portWrData;
   logic [7:0] portRdData;
   logic       portSel;

   int checks = 0;
   int errors = 0;

   riscuva_irq_ctrl dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .irqSrc      (irqSrc),
      .intReq      (intReq),
      .intAck      (intAck),
      .portAddress (portAddress),
      .portRead    (portRead),
      .portWrite   (portWrite),
      .portWrData  (portWrData),
      .portRdData  (portRdData),
      .portSel     (portSel)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   task automatic rd(input logic [7:0] addr, output logic [7:0] data, output logic sel);
      portAddress = addr;
      portRead    = 1'b1;
      #1;
      data        = portRdData;
      sel         = portSel;
      portRead    = 1'b0;
   endtask

   task automatic check_reg(input string tag, input logic [7:0] addr, input logic [7:0] exp);
      logic [7:0] d;
      logic       s;
      rd(addr, d, s);
      check_eq(tag, d, exp);
   endtask

   task automatic wr(input logic [7:0] addr, input logic [7:0] data);
      @(negedge clk);
      portAddress = addr;
      portWrData  = data;
      portWrite   = 1'b1;
      @(negedge clk);
      portWrite   = 1'b0;
   endtask

   task automatic pulse(input logic [7:0] s);
      @(negedge clk);
      irqSrc = s;
      @(negedge clk);
      irqSrc = 8'h00;
   endtask

   task automatic wait_req(input string tag);
      logic ok = 1'b0;
      for (int n = 0; n < 30 && !ok; n++) begin
         @(negedge clk);
         if (intReq) ok = 1'b1;
      end
      check_eq(tag, {7'b0, ok}, 8'h01);
   endtask

   // Core behaviour: raise intAck one cycle after sampling intReq; return just after the claim edge.
   task automatic ack;
      @(negedge clk);
      intAck = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] d, m, s, rem;
      logic       sel, seen;
      int         q[$];

      reset_n = 1'b0; irqSrc = 8'h00; intAck = 1'b0;
      portAddress = 8'h00; portRead = 1'b0; portWrite = 1'b0; portWrData = 8'h00;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      check_eq("rst_intreq", {7'b0, intReq}, 8'h00);
      check_reg("rst_pend", A_PEND, 8'h00);
      check_reg("rst_mask", A_MASK, 8'h00);
      check_reg("rst_edge", A_EDGE, 8'h00);
      check_reg("rst_vect", A_VECT, 8'h00);

      // Address decode: outside the window, and read strobe low.
      wr(A_MASK, 8'h5A);
      rd(8'hF4, d, sel);
      check_eq("dec_out_data", d, 8'h00);
      check_eq("dec_out_sel", {7'b0, sel}, 8'h00);
      rd(A_MASK, d, sel);
      check_eq("dec_in_data", d, 8'h5A);
      check_eq("dec_in_sel", {7'b0, sel}, 8'h01);
      portAddress = A_MASK; portRead = 1'b0; #1;
      check_eq("dec_noread_sel", {7'b0, portSel}, 8'h00);
      check_eq("dec_noread_data", portRdData, 8'h00);
      check_reg("vect_ro_before", A_VECT, 8'h00);
      wr(A_VECT, 8'hFF);
      check_reg("vect_ro_after", A_VECT, 8'h00);

      // Edge source 2: latency, claim and RETI.
      wr(A_MASK, 8'h05);
      wr(A_EDGE, 8'h05);
      pulse(8'h04);
      @(negedge clk);
      @(negedge clk);
      check_eq("t1_req_t3", {7'b0, intReq}, 8'h00);
      check_reg("t1_pend_t3", A_PEND, 8'h04);
      @(negedge clk);
      check_eq("t1_req_t4", {7'b0, intReq}, 8'h01);
      ack();
      check_reg("t1_vect_svc", A_VECT, 8'h82);
      check_reg("t1_pend_clr", A_PEND, 8'h00);
      check_eq("t1_req_svc", {7'b0, intReq}, 8'h00);
      intAck = 1'b0;
      @(negedge clk);
      check_reg("t1_vect_reti", A_VECT, 8'h02);

      // Two simultaneous edges: lowest index first.
      wr(A_MASK, 8'h22);
      wr(A_EDGE, 8'h22);
      pulse(8'h22);
      wait_req("t2_req1");
      ack();
      check_reg("t2_vect1", A_VECT, 8'h81);
      check_reg("t2_pend1", A_PEND, 8'h20);
      intAck = 1'b0;
      @(negedge clk);
      check_eq("t2_req_r1", {7'b0, intReq}, 8'h00);
      @(negedge clk);
      check_eq("t2_req_r2", {7'b0, intReq}, 8'h01);
      ack();
      check_reg("t2_vect2", A_VECT, 8'h85);
      check_reg("t2_pend2", A_PEND, 8'h00);
      intAck = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("t2_req_idle", {7'b0, intReq}, 8'h00);

      // Level source 3 held high.
      wr(A_EDGE, 8'h00);
      wr(A_MASK, 8'h08);
      @(negedge clk);
      irqSrc = 8'h08;
      wait_req("t3_req1");
      ack();
      check_reg("t3_vect1", A_VECT, 8'h83);
      check_reg("t3_pend1", A_PEND, 8'h08);
      intAck = 1'b0;
      @(negedge clk);
      check_eq("t3_req_r1", {7'b0, intReq}, 8'h00);
      @(negedge clk);
      check_eq("t3_req_r2", {7'b0, intReq}, 8'h01);
      ack();
      check_reg("t3_vect2", A_VECT, 8'h83);
      irqSrc = 8'h00;
      repeat (4) @(negedge clk);
      check_reg("t3_pend_quiet", A_PEND, 8'h00);
      intAck = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("t3_req_quiet", {7'b0, intReq}, 8'h00);
      check_reg("t3_vect_reti", A_VECT, 8'h03);

      // Request withdrawn by a MASK write on the edge the core raises intAck.
      wr(A_EDGE, 8'h01);
      wr(A_MASK, 8'h01);
      pulse(8'h01);
      wait_req("t4_req");
      portAddress = A_MASK; portWrData = 8'h00; portWrite = 1'b1;
      @(posedge clk);
      #1;
      intAck = 1'b1;
      portWrite = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_reg("t4_vect_spur", A_VECT, 8'h88);
      check_eq("t4_req_svc", {7'b0, intReq}, 8'h00);
      check_reg("t4_pend_kept", A_PEND, 8'h01);
      intAck = 1'b0;
      wr(A_PEND, 8'hFF);
      check_reg("t4_pend_w1c", A_PEND, 8'h00);

      // W1C coinciding with a fresh rising edge: set wins.
      wr(A_EDGE, 8'h10);
      pulse(8'h10);
      repeat (3) @(negedge clk);
      check_reg("t5_pend_set", A_PEND, 8'h10);
      irqSrc = 8'h10;
      @(negedge clk);
      @(negedge clk);
      portAddress = A_PEND; portWrData = 8'h10; portWrite = 1'b1;
      @(negedge clk);
      portWrite = 1'b0;
      check_reg("t5_set_wins", A_PEND, 8'h10);
      irqSrc = 8'h00;
      wr(A_PEND, 8'h10);
      check_reg("t5_w1c_only", A_PEND, 8'h00);

      // Reset in the middle of SERVICE.
      wr(A_EDGE, 8'h01);
      wr(A_MASK, 8'h01);
      pulse(8'h01);
      wait_req("t6_req");
      ack();
      check_reg("t6_vect_svc", A_VECT, 8'h80);
      reset_n = 1'b0;
      intAck  = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      check_eq("t6_req_rst", {7'b0, intReq}, 8'h00);
      check_reg("t6_pend", A_PEND, 8'h00);
      check_reg("t6_mask", A_MASK, 8'h00);
      check_reg("t6_edge", A_EDGE, 8'h00);
      check_reg("t6_vect", A_VECT, 8'h00);
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (intReq) seen = 1'b1;
      end
      check_eq("t6_no_req", {7'b0, seen}, 8'h00);
      wr(A_EDGE, 8'h01);
      wr(A_MASK, 8'h01);
      pulse(8'h01);
      wait_req("t6_fresh_req");
      ack();
      check_reg("t6_fresh_vect", A_VECT, 8'h80);
      intAck = 1'b0;
      @(negedge clk);

      // Randomized bursts of edge events against a claim-order model.
      for (int it = 0; it < 12; it++) begin
         wr(A_EDGE, 8'hFF);
         wr(A_PEND, 8'hFF);
         m = 8'($urandom_range(1, 255));
         s = 8'($urandom_range(1, 255));
         wr(A_MASK, m);
         pulse(s);
         repeat (2) @(negedge clk);
         check_reg("rnd_pend_latched", A_PEND, s);
         q.delete();
         for (int b = 0; b < 8; b++) if (s[b] && m[b]) q.push_back(b);
         rem = s & ~m;
         while (q.size() > 0) begin
            wait_req("rnd_req");
            ack();
            check_reg("rnd_vect", A_VECT, 8'h80 | 8'(q.pop_front()));
            intAck = 1'b0;
            @(negedge clk);
         end
         seen = 1'b0;
         repeat (6) begin
            @(negedge clk);
            if (intReq) seen = 1'b1;
         end
         check_eq("rnd_no_extra_req", {7'b0, seen}, 8'h00);
         check_reg("rnd_pend_left", A_PEND, rem);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
